// File: rtl/prog_counter_pkg.sv
// Shared types for the educational CPU program counter.
package prog_counter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2,
    HALT = 2'd3
  } state_t;

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector for an already-debounced level input; reusable for any button.
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic pulse
);

  logic prev;

  always_ff @(posedge clk) begin
    if (rst) prev <= 1'b0;
    else     prev <= d;
  end

  assign pulse = d & ~prev;

endmodule

// File: rtl/prog_counter.sv
// Program counter with free-run, single-step and jump-to-self halt detection.
module prog_counter
  import prog_counter_pkg::*;
#(
  parameter int unsigned     WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode_run,
  input  logic             en,
  input  logic             step_req,
  input  logic             jmp,
  input  logic             jmp_ok,
  input  logic [WIDTH-1:0] jmp_addr,
  output logic [WIDTH-1:0] pc,
  output logic             wrap,
  output logic             halted
);

  state_t           state;
  logic             step_pulse;
  logic             advance;
  logic             taken;
  logic             self_jump;
  logic [WIDTH-1:0] pc_inc;

  // History updates in every state so a button held on entry to STEP gives no pulse.
  rise_detect u_step_edge (
    .clk  (clk),
    .rst  (rst),
    .d    (step_req),
    .pulse(step_pulse)
  );

  always_comb begin
    advance = 1'b0;
    case (state)
      RUN:     advance = en;
      STEP:    advance = step_pulse;
      default: advance = 1'b0;
    endcase
    taken     = jmp & jmp_ok;
    pc_inc    = pc + WIDTH'(1);
    self_jump = advance & taken & (jmp_addr == pc);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      pc     <= RESET_VAL;
      wrap   <= 1'b0;
      halted <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (advance) begin
        if (taken) begin
          pc <= jmp_addr;
        end else begin
          pc   <= pc_inc;
          wrap <= &pc;
        end
      end

      case (state)
        IDLE: begin
          if (start) state <= mode_run ? RUN : STEP;
        end
        RUN: begin
          if (self_jump) begin
            state  <= HALT;
            halted <= 1'b1;
          end else if (!mode_run) begin
            state <= STEP;
          end
        end
        STEP: begin
          if (self_jump) begin
            state  <= HALT;
            halted <= 1'b1;
          end else if (mode_run) begin
            state <= RUN;
          end
        end
        HALT: begin
          halted <= 1'b1;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_counter.sv
// Randomized and directed checks of prog_counter against a behavioural model.
module tb_prog_counter;

  localparam int unsigned WIDTH = 4;
  localparam int          NPC   = 16;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_STEP = 2;
  localparam int M_HALT = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             mode_run = 1'b0;
  logic             en = 1'b0;
  logic             step_req = 1'b0;
  logic             jmp = 1'b0;
  logic             jmp_ok = 1'b0;
  logic [WIDTH-1:0] jmp_addr = '0;
  logic [WIDTH-1:0] pc;
  logic             wrap;
  logic             halted;
  logic [WIDTH-1:0] pc3;
  logic             wrap3;
  logic             halted3;

  int checks = 0;
  int failures = 0;

  int m_mode = M_IDLE;
  int m_pc = 0;
  bit m_wrap = 1'b0;
  bit m_halted = 1'b0;
  bit m_prev = 1'b0;

  prog_counter #(.WIDTH(WIDTH), .RESET_VAL(4'h0)) dut (
    .clk(clk), .rst(rst), .start(start), .mode_run(mode_run), .en(en),
    .step_req(step_req), .jmp(jmp), .jmp_ok(jmp_ok), .jmp_addr(jmp_addr),
    .pc(pc), .wrap(wrap), .halted(halted)
  );

  prog_counter #(.WIDTH(WIDTH), .RESET_VAL(4'h3)) dut3 (
    .clk(clk), .rst(rst), .start(start), .mode_run(mode_run), .en(en),
    .step_req(step_req), .jmp(jmp), .jmp_ok(jmp_ok), .jmp_addr(jmp_addr),
    .pc(pc3), .wrap(wrap3), .halted(halted3)
  );

  always #5 clk = ~clk;

  // Apply the behavioural rules to the inputs present in this cycle.
  task automatic model_step();
    bit pulse;
    bit adv;
    int next_mode;
    if (rst) begin
      m_mode = M_IDLE; m_pc = 0; m_wrap = 1'b0; m_halted = 1'b0; m_prev = 1'b0;
      return;
    end
    pulse = step_req && !m_prev;
    adv = (m_mode == M_RUN) ? en : (m_mode == M_STEP) ? pulse : 1'b0;
    next_mode = m_mode;
    if (m_mode == M_IDLE && start) next_mode = mode_run ? M_RUN : M_STEP;
    if (m_mode == M_RUN && !mode_run) next_mode = M_STEP;
    if (m_mode == M_STEP && mode_run) next_mode = M_RUN;
    m_wrap = 1'b0;
    if (adv) begin
      if (jmp && jmp_ok) begin
        if (int'(jmp_addr) == m_pc) next_mode = M_HALT;
        m_pc = int'(jmp_addr);
      end else begin
        m_wrap = (m_pc == NPC - 1);
        m_pc = (m_pc + 1) % NPC;
      end
    end
    m_prev = step_req;
    m_mode = next_mode;
    m_halted = (m_mode == M_HALT);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic jump_to(input int v);
    en = 1'b1; jmp = 1'b1; jmp_ok = 1'b1; jmp_addr = WIDTH'(v);
    tick();
    en = 1'b0; jmp = 1'b0; jmp_ok = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    checks++; if (pc !== 4'h0) begin failures++; $display("FAIL reset_pc got=%0h exp=0", pc); end
    checks++; if (pc3 !== 4'h3) begin failures++; $display("FAIL reset_pc_rv3 got=%0h exp=3", pc3); end
    checks++; if (wrap !== 1'b0) begin failures++; $display("FAIL reset_wrap got=%b exp=0", wrap); end
    checks++; if (halted !== 1'b0) begin failures++; $display("FAIL reset_halted got=%b exp=0", halted); end
    en = 1'b1;
    repeat (3) tick();
    en = 1'b0;
    checks++; if (pc !== 4'h0) begin failures++; $display("FAIL idle_hold got=%0h exp=0", pc); end
  endtask

  task automatic test_free_run();
    start = 1'b1; mode_run = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (pc !== 4'h0) begin failures++; $display("FAIL start_no_advance got=%0h exp=0", pc); end
    en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      checks++; if (pc !== WIDTH'(m_pc)) begin failures++; $display("FAIL freerun_pc i=%0d got=%0h exp=%0h", i, pc, m_pc); end
      checks++; if (wrap !== m_wrap) begin failures++; $display("FAIL freerun_wrap i=%0d got=%b exp=%b", i, wrap, m_wrap); end
    end
    checks++; if (pc !== 4'h0 || wrap !== 1'b1) begin failures++; $display("FAIL wrap_point pc=%0h wrap=%b exp pc=0 wrap=1", pc, wrap); end
    en = 1'b0;
    tick();
    checks++; if (wrap !== 1'b0) begin failures++; $display("FAIL wrap_one_cycle got=%b exp=0", wrap); end
    for (int i = 0; i < 9; i++) begin
      en = (i % 3 == 2);
      tick();
      checks++; if (pc !== WIDTH'(m_pc)) begin failures++; $display("FAIL en_every3 i=%0d got=%0h exp=%0h", i, pc, m_pc); end
    end
    en = 1'b0;
    checks++; if (pc !== 4'h3) begin failures++; $display("FAIL en_every3_total got=%0h exp=3", pc); end
  endtask

  task automatic test_jump();
    rst = 1'b1; tick(); rst = 1'b0;
    start = 1'b1; mode_run = 1'b1; tick(); start = 1'b0;
    jump_to(5);
    checks++; if (pc !== 4'h5) begin failures++; $display("FAIL jump_setup got=%0h exp=5", pc); end
    jump_to(9);
    checks++; if (pc !== 4'h9) begin failures++; $display("FAIL jump_taken got=%0h exp=9", pc); end
    jump_to(5);
    en = 1'b1; jmp = 1'b1; jmp_ok = 1'b0; jmp_addr = 4'h9;
    tick();
    en = 1'b0; jmp = 1'b0;
    checks++; if (pc !== 4'h6) begin failures++; $display("FAIL jump_not_taken got=%0h exp=6", pc); end
    jump_to(7);
    jump_to(0);
    checks++; if (pc !== 4'h0 || wrap !== 1'b0) begin failures++; $display("FAIL jump_to_zero pc=%0h wrap=%b exp pc=0 wrap=0", pc, wrap); end
  endtask

  task automatic test_step();
    step_req = 1'b1;
    tick();
    mode_run = 1'b0;
    tick();
    repeat (3) tick();
    checks++; if (pc !== 4'h0) begin failures++; $display("FAIL step_held_on_entry got=%0h exp=0", pc); end
    step_req = 1'b0; tick();
    step_req = 1'b1;
    repeat (10) tick();
    checks++; if (pc !== 4'h1) begin failures++; $display("FAIL step_hold got=%0h exp=1", pc); end
    step_req = 1'b0; tick();
    step_req = 1'b1; tick();
    step_req = 1'b0;
    checks++; if (pc !== 4'h2) begin failures++; $display("FAIL step_repress got=%0h exp=2", pc); end
    en = 1'b1;
    repeat (3) tick();
    en = 1'b0;
    checks++; if (pc !== 4'h2) begin failures++; $display("FAIL step_ignores_en got=%0h exp=2", pc); end
  endtask

  task automatic test_halt();
    mode_run = 1'b1; tick();
    jump_to(10);
    en = 1'b1; jmp = 1'b1; jmp_ok = 1'b1; jmp_addr = 4'hA;
    tick();
    jmp = 1'b0;
    checks++; if (halted !== 1'b1 || pc !== 4'hA) begin failures++; $display("FAIL halt_enter halted=%b pc=%0h exp halted=1 pc=a", halted, pc); end
    start = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step_req = i[0];
      mode_run = i[1];
      tick();
    end
    start = 1'b0; step_req = 1'b0; en = 1'b0; mode_run = 1'b1;
    checks++; if (halted !== 1'b1 || pc !== 4'hA) begin failures++; $display("FAIL halt_hold halted=%b pc=%0h exp halted=1 pc=a", halted, pc); end
    rst = 1'b1; tick(); rst = 1'b0;
    checks++; if (halted !== 1'b0 || pc !== 4'h0) begin failures++; $display("FAIL halt_reset halted=%b pc=%0h exp halted=0 pc=0", halted, pc); end
  endtask

  task automatic test_reset_mid();
    start = 1'b1; mode_run = 1'b1; tick(); start = 1'b0;
    jump_to(2);
    rst = 1'b1; en = 1'b1; jmp = 1'b1; jmp_ok = 1'b1; jmp_addr = 4'hC;
    tick();
    rst = 1'b0; jmp = 1'b0; jmp_ok = 1'b0;
    checks++; if (pc !== 4'h0 || wrap !== 1'b0) begin failures++; $display("FAIL reset_vs_jump pc=%0h wrap=%b exp pc=0 wrap=0", pc, wrap); end
    repeat (3) tick();
    checks++; if (pc !== 4'h0) begin failures++; $display("FAIL reset_needs_start got=%0h exp=0", pc); end
    start = 1'b1; tick(); start = 1'b0;
    tick();
    en = 1'b0;
    checks++; if (pc !== 4'h1) begin failures++; $display("FAIL resume_after_start got=%0h exp=1", pc); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      rst      = ($urandom % 30) == 0;
      start    = ($urandom % 4) == 0;
      if (($urandom % 12) == 0) mode_run = ~mode_run;
      en       = ($urandom % 2) == 1;
      if (($urandom % 3) == 0) step_req = ~step_req;
      jmp      = ($urandom % 4) == 0;
      jmp_ok   = ($urandom % 2) == 1;
      jmp_addr = (($urandom % 8) == 0) ? WIDTH'(m_pc) : WIDTH'($urandom);
      tick();
      checks++; if (pc !== WIDTH'(m_pc)) begin failures++; $display("FAIL rand_pc i=%0d got=%0h exp=%0h", i, pc, m_pc); end
      checks++; if (wrap !== m_wrap) begin failures++; $display("FAIL rand_wrap i=%0d got=%b exp=%b", i, wrap, m_wrap); end
      checks++; if (halted !== m_halted) begin failures++; $display("FAIL rand_halted i=%0d got=%b exp=%b", i, halted, m_halted); end
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_jump();
    test_step();
    test_halt();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
